// File: rtl/watch_ctrl_unit_gen.sv
`default_nettype none
// ============================================================================
// watch_ctrl_unit_gen : watch/stopwatch control FSM with N-field watch edit,
// tick-based auto-repeat, lap freeze and edit inactivity lockout.
// Revision: 1.0
// ============================================================================
module watch_ctrl_unit_gen #(
    parameter int NUM_FIELDS    = 4,
    parameter int FIELD_W       = 3,
    parameter int REPEAT_DELAY  = 5,
    parameter int REPEAT_RATE   = 2,
    parameter int TIMEOUT_TICKS = 50,
    parameter int CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_tick,
    input  logic                  i_up,
    input  logic                  i_down,
    input  logic                  i_right,
    input  logic                  i_left,
    input  logic                  i_watch_select,
    input  logic                  i_edit,
    output logic                  o_run_stop,
    output logic                  o_clear,
    output logic                  o_lap,
    output logic [NUM_FIELDS-1:0] o_edit_sel,
    output logic                  o_edit_inc,
    output logic                  o_edit_dec,
    output logic                  o_edit_locked
);

    localparam logic [1:0] ST_STOP  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_UP   = 2'd1;
    localparam logic [1:0] SRC_DOWN = 2'd2;

    localparam logic [FIELD_W-1:0] LAST_FIELD = FIELD_W'(NUM_FIELDS - 1);
    localparam logic [CNT_W-1:0]   REP_FIRST  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0]   REP_NEXT   = CNT_W'(REPEAT_DELAY + REPEAT_RATE);
    localparam logic [CNT_W-1:0]   TO_LIMIT   = CNT_W'(TIMEOUT_TICKS);

    logic               up_q, down_q, right_q, left_q;
    logic               up_p, down_p, right_p, left_p, any_p;
    logic               act_up, act_down, act_right, act_left;

    logic [1:0]         state, state_next;
    logic               lap_next, run_next, clear_next;

    logic               edit_active;
    logic [FIELD_W-1:0] field_idx;
    logic [1:0]         rep_src, src_now;
    logic [CNT_W-1:0]   rep_cnt, rep_inc;
    logic [CNT_W-1:0]   to_cnt, to_inc;
    logic               rep_hit, timeout_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            right_q <= 1'b0;
            left_q  <= 1'b0;
        end else begin
            up_q    <= i_up;
            down_q  <= i_down;
            right_q <= i_right;
            left_q  <= i_left;
        end
    end

    assign up_p    = i_up    & ~up_q;
    assign down_p  = i_down  & ~down_q;
    assign right_p = i_right & ~right_q;
    assign left_p  = i_left  & ~left_q;
    assign any_p   = up_p | down_p | right_p | left_p;

    // Only the highest-priority press of a cycle becomes an action.
    assign act_up    = up_p;
    assign act_down  = down_p  & ~up_p;
    assign act_right = right_p & ~up_p & ~down_p;
    assign act_left  = left_p  & ~up_p & ~down_p & ~right_p;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_STOP;
            o_lap      <= 1'b0;
            o_run_stop <= 1'b0;
            o_clear    <= 1'b0;
        end else begin
            state      <= state_next;
            o_lap      <= lap_next;
            o_run_stop <= run_next;
            o_clear    <= clear_next;
        end
    end

    always_comb begin
        state_next = state;
        lap_next   = o_lap;
        case (state)
            ST_STOP: begin
                if (i_watch_select) begin
                    if (act_right)     state_next = ST_RUN;
                    else if (act_left) state_next = ST_CLEAR;
                end
            end
            ST_RUN: begin
                if (i_watch_select) begin
                    if (act_right) begin
                        state_next = ST_STOP;
                        lap_next   = 1'b0;
                    end else if (act_left) begin
                        lap_next   = ~o_lap;
                    end
                end
            end
            ST_CLEAR: state_next = ST_STOP;
            default:  state_next = ST_STOP;
        endcase
    end

    always_comb begin
        run_next   = (state_next == ST_RUN);
        clear_next = (state_next == ST_CLEAR);
    end

    assign edit_active = i_edit & ~i_watch_select & ~o_edit_locked;
    assign src_now     = i_up ? SRC_UP : (i_down ? SRC_DOWN : SRC_NONE);
    assign rep_inc     = rep_cnt + 1'b1;
    assign to_inc      = to_cnt + 1'b1;
    // A repeat pulse fires at the first delay, then each time the rate elapses.
    assign rep_hit     = (rep_inc == REP_FIRST) || (rep_inc == REP_NEXT);
    assign timeout_hit = edit_active & ~any_p & i_tick & (to_inc == TO_LIMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rep_src    <= SRC_NONE;
            rep_cnt    <= '0;
            o_edit_inc <= 1'b0;
            o_edit_dec <= 1'b0;
        end else begin
            o_edit_inc <= 1'b0;
            o_edit_dec <= 1'b0;
            if (!edit_active) begin
                rep_src <= SRC_NONE;
                rep_cnt <= '0;
            end else begin
                rep_src <= src_now;
                if (act_up || act_down) begin
                    rep_cnt    <= '0;
                    o_edit_inc <= act_up;
                    o_edit_dec <= act_down;
                end else if ((src_now != rep_src) || (src_now == SRC_NONE)) begin
                    rep_cnt <= '0;
                end else if (i_tick) begin
                    if (rep_hit) begin
                        rep_cnt    <= REP_FIRST;
                        o_edit_inc <= (src_now == SRC_UP);
                        o_edit_dec <= (src_now == SRC_DOWN);
                    end else begin
                        rep_cnt <= rep_inc;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt        <= '0;
            o_edit_locked <= 1'b0;
            field_idx     <= '0;
        end else begin
            if (!edit_active || any_p || timeout_hit) begin
                to_cnt <= '0;
            end else if (i_tick) begin
                to_cnt <= to_inc;
            end

            if (o_edit_locked) begin
                if (!i_edit) o_edit_locked <= 1'b0;
            end else if (timeout_hit) begin
                o_edit_locked <= 1'b1;
            end

            if (timeout_hit) begin
                field_idx <= '0;
            end else if (edit_active && act_left) begin
                field_idx <= (field_idx == LAST_FIELD) ? '0 : field_idx + 1'b1;
            end else if (edit_active && act_right) begin
                field_idx <= (field_idx == '0) ? LAST_FIELD : field_idx - 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_sel
        assign o_edit_sel[g] = edit_active & (field_idx == FIELD_W'(g));
    end

endmodule
`default_nettype wire
